// File: rtl/rapcore_spi_host.sv
// rapcore_spi_host
//   SPI initiator (mode 0, MSB first) that drives the SCK/CS/COPI/CIPO target
//   port of a rapcore from a word-wide valid/ready stream. Each accepted word is
//   shifted out on COPI while CIPO is shifted in. The received word appears on
//   rx_data together with a one-cycle rx_valid pulse. CS stays low across words
//   until a word flagged tx_last completes. A minimum CS-high gap then follows
//   before the next frame may start.
//
// Ports
//   CLK, resetn        system clock (rising edge), asynchronous active-low reset
//   tx_data/last/valid word to send, end-of-frame flag, valid strobe
//   tx_ready           word accepted when tx_valid && tx_ready
//   rx_data, rx_valid  received word, one-cycle update strobe
//   abort              drop the current frame (ignored in IDLE/GAP)
//   busy               high whenever the controller is not IDLE
//   SCK, CS, COPI      SPI outputs (SCK idles low, CS active low)
//   CIPO               SPI input, assumed synchronous to CLK
module rapcore_spi_host #(
  parameter int WORD_BITS = 64,
  parameter int CLK_DIV   = 4
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_last,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 abort,
  output logic                 busy,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
  input  logic                 CIPO
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [WORD_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 last_q, last_d;
  logic                 sck_q, sck_d;
  logic                 cs_q, cs_d;
  logic                 copi_q, copi_d;

  logic tick;
  logic handshake;

  assign tick      = (div_q == DW'(CLK_DIV - 1));
  assign tx_ready  = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign handshake = tx_valid && tx_ready;

  assign SCK      = sck_q;
  assign CS       = cs_q;
  assign COPI     = copi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    copi_d     = copi_q;

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (handshake) begin
          tx_sr_d   = tx_data;
          last_d    = tx_last;
          cs_d      = 1'b0;
          copi_d    = tx_data[WORD_BITS-1];
          bit_cnt_d = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick) begin
          if (!sck_q) begin
            // Rising edge: sample the target's bit.
            sck_d     = 1'b1;
            rx_sr_d   = {rx_sr_q[WORD_BITS-2:0], CIPO};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == BW'(WORD_BITS)) begin
            // Final falling edge: no further COPI bit, publish the word.
            sck_d      = 1'b0;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? S_HOLD : S_WAIT;
          end else begin
            // Falling edge: present the next bit a full half-period early.
            sck_d   = 1'b0;
            copi_d  = tx_sr_q[WORD_BITS-2];
            tx_sr_d = tx_sr_q << 1;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          cs_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over anything decided above, including word completion.
    if (abort && (state_q != S_IDLE) && (state_q != S_GAP)) begin
      cs_d       = 1'b1;
      sck_d      = 1'b0;
      copi_d     = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      state_d    = S_GAP;
    end

    // Every state starts with a full divider period.
    if (state_d != state_q) div_d = '0;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      copi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      copi_q     <= copi_d;
    end
  end

endmodule

// File: tb/tb_rapcore_spi_host.sv
// Bench for rapcore_spi_host. Two instances share the clock and reset:
// instance 0 uses CLK_DIV=2, instance 1 uses CLK_DIV=1. A monitor acts as the
// mode-0 target (captures COPI on each SCK rise) and keeps running counts
// that the tests compare as deltas against hand-computed expectations.
module tb_rapcore_spi_host;

  localparam int W   = 64;
  localparam int CDA = 2;
  localparam int CDB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [W-1:0] txd   [2];
  logic         txl   [2];
  logic         txv   [2];
  logic         abt   [2];
  logic         cmode [2];

  logic         rdy_v  [2];
  logic         rxv_v  [2];
  logic         busy_v [2];
  logic         sck_v  [2];
  logic         cs_v   [2];
  logic         copi_v [2];
  logic         cipo_v [2];
  logic [W-1:0] rxd_v  [2];

  // Target side: either loop COPI back or hold CIPO high.
  assign cipo_v[0] = cmode[0] ? 1'b1 : copi_v[0];
  assign cipo_v[1] = cmode[1] ? 1'b1 : copi_v[1];

  rapcore_spi_host #(.WORD_BITS(W), .CLK_DIV(CDA)) u_a (
    .CLK(clk), .resetn(resetn),
    .tx_data(txd[0]), .tx_last(txl[0]), .tx_valid(txv[0]), .tx_ready(rdy_v[0]),
    .rx_data(rxd_v[0]), .rx_valid(rxv_v[0]), .abort(abt[0]), .busy(busy_v[0]),
    .SCK(sck_v[0]), .CS(cs_v[0]), .COPI(copi_v[0]), .CIPO(cipo_v[0])
  );

  rapcore_spi_host #(.WORD_BITS(W), .CLK_DIV(CDB)) u_b (
    .CLK(clk), .resetn(resetn),
    .tx_data(txd[1]), .tx_last(txl[1]), .tx_valid(txv[1]), .tx_ready(rdy_v[1]),
    .rx_data(rxd_v[1]), .rx_valid(rxv_v[1]), .abort(abt[1]), .busy(busy_v[1]),
    .SCK(sck_v[1]), .CS(cs_v[1]), .COPI(copi_v[1]), .CIPO(cipo_v[1])
  );

  // ---------------- monitor / model target ----------------
  int           cyc = 0;
  int           rises   [2] = '{0, 0};
  int           rxv_cnt [2] = '{0, 0};
  int           per_err [2] = '{0, 0};
  int           cs_bad  [2] = '{0, 0};
  int           gap     [2] = '{0, 0};
  int           cs_rise [2] = '{0, 0};
  int           last_r  [2] = '{0, 0};
  logic [W-1:0] tgt     [2] = '{default: '0};
  logic [W-1:0] rx_last [2] = '{default: '0};
  logic [W-1:0] rx_prev [2] = '{default: '0};
  logic         psck    [2] = '{1'b0, 1'b0};
  logic         pcs     [2] = '{1'b1, 1'b1};
  logic         pr_ok   [2] = '{1'b0, 1'b0};
  logic         rise_v  [2];

  assign rise_v[0] = sck_v[0] & ~psck[0];
  assign rise_v[1] = sck_v[1] & ~psck[1];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cd_of(input int i);
    return (i == 0) ? CDA : CDB;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      psck[i] <= sck_v[i];
      pcs[i]  <= cs_v[i];
      if (rise_v[i]) begin
        rises[i]  <= rises[i] + 1;
        tgt[i]    <= {tgt[i][W-2:0], copi_v[i]};
        last_r[i] <= cyc;
        if (cs_v[i]) cs_bad[i] <= cs_bad[i] + 1;
        if (pr_ok[i] && ((cyc - last_r[i]) != 2 * cd_of(i))) per_err[i] <= per_err[i] + 1;
      end
      pr_ok[i] <= (rise_v[i] | pr_ok[i]) & ~rxv_v[i] & ~cs_v[i];
      if (rxv_v[i]) begin
        rxv_cnt[i] <= rxv_cnt[i] + 1;
        rx_prev[i] <= rx_last[i];
        rx_last[i] <= rxd_v[i];
      end
      if (cs_v[i] && busy_v[i]) gap[i] <= gap[i] + 1;
      if (cs_v[i] && !pcs[i]) cs_rise[i] <= cs_rise[i] + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [63:0] d, input logic l);
    int n = 0;
    while (!rdy_v[s] && n < 2000) begin step(); n++; end
    chk($sformatf("tx_ready wait dut%0d", s), 64'(n < 2000), 64'd1);
    txd[s] = d;
    txl[s] = l;
    txv[s] = 1'b1;
    step();
    txv[s] = 1'b0;
  endtask

  task automatic wait_rxv(input int s, input int target);
    int n = 0;
    while (rxv_cnt[s] < target && n < 2000) begin step(); n++; end
    chk($sformatf("rx_valid wait dut%0d", s), 64'(n < 2000), 64'd1);
  endtask

  task automatic wait_rises(input int s, input int target);
    int n = 0;
    while (rises[s] < target && n < 2000) begin step(); n++; end
    chk($sformatf("sck rise wait dut%0d", s), 64'(n < 2000), 64'd1);
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    while (busy_v[s] && n < 2000) begin step(); n++; end
    chk($sformatf("idle wait dut%0d", s), 64'(n < 2000), 64'd1);
  endtask

  // Single-word frame with full set of per-frame checks.
  task automatic frame(input string name, input int s, input logic [63:0] d, input logic [63:0] exp_rx);
    int r0, v0, p0, b0, g0;
    r0 = rises[s]; v0 = rxv_cnt[s]; p0 = per_err[s]; b0 = cs_bad[s]; g0 = gap[s];
    send(s, d, 1'b1);
    wait_rxv(s, v0 + 1);
    wait_idle(s);
    step();
    chk({name, " rx_data"},     rxd_v[s], exp_rx);
    chk({name, " rx_pulses"},   64'(rxv_cnt[s] - v0), 64'd1);
    chk({name, " sck_rises"},   64'(rises[s] - r0), 64'd64);
    chk({name, " target_word"}, tgt[s], d);
    chk({name, " sck_period"},  64'(per_err[s] - p0), 64'd0);
    chk({name, " cs_at_rise"},  64'(cs_bad[s] - b0), 64'd0);
    chk({name, " cs_gap_ok"},   64'((gap[s] - g0) >= cd_of(s)), 64'd1);
    chk({name, " tx_ready"},    64'(rdy_v[s]), 64'd1);
  endtask

  typedef struct {
    string        name;
    int           sel;
    logic         cipo_one;
    logic [63:0]  data;
    logic [63:0]  exp_rx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] saved;
    int r0, v0, g0, c0, p0;

    vecs[0] = '{"loop_deadbeef_div2", 0, 1'b0, 64'hDEADBEEF01234567, 64'hDEADBEEF01234567};
    vecs[1] = '{"cipo1_zero_div2",    0, 1'b1, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
    vecs[2] = '{"loop_ones_div2",     0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{"loop_deadbeef_div1", 1, 1'b0, 64'hDEADBEEF01234567, 64'hDEADBEEF01234567};
    vecs[4] = '{"loop_ends_div1",     1, 1'b0, 64'h8000000000000001, 64'h8000000000000001};
    vecs[5] = '{"cipo1_mixed_div1",   1, 1'b1, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF};

    resetn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      txd[s] = '0; txl[s] = 1'b0; txv[s] = 1'b0; abt[s] = 1'b0; cmode[s] = 1'b0;
    end
    repeat (3) step();

    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset cs dut%0d", s),       64'(cs_v[s]),   64'd1);
      chk($sformatf("reset sck dut%0d", s),      64'(sck_v[s]),  64'd0);
      chk($sformatf("reset copi dut%0d", s),     64'(copi_v[s]), 64'd0);
      chk($sformatf("reset rx_data dut%0d", s),  rxd_v[s],       64'd0);
      chk($sformatf("reset rx_valid dut%0d", s), 64'(rxv_v[s]),  64'd0);
      chk($sformatf("reset busy dut%0d", s),     64'(busy_v[s]), 64'd0);
      chk($sformatf("reset tx_ready dut%0d", s), 64'(rdy_v[s]),  64'd1);
    end
    resetn = 1'b1;
    step();

    // Table-driven single-word frames.
    for (int i = 0; i < 6; i++) begin
      cmode[vecs[i].sel] = vecs[i].cipo_one;
      frame(vecs[i].name, vecs[i].sel, vecs[i].data, vecs[i].exp_rx);
    end
    cmode[0] = 1'b0;
    cmode[1] = 1'b0;

    // Back-to-back words in one frame: CS must stay low between them.
    r0 = rises[0]; v0 = rxv_cnt[0]; c0 = cs_rise[0]; p0 = per_err[0];
    send(0, 64'hA5A5A5A5A5A5A5A5, 1'b0);
    send(0, 64'h5A5A5A5A5A5A5A5A, 1'b1);
    wait_rxv(0, v0 + 2);
    wait_idle(0);
    step();
    chk("b2b rx_pulses",  64'(rxv_cnt[0] - v0), 64'd2);
    chk("b2b sck_rises",  64'(rises[0] - r0),   64'd128);
    chk("b2b cs_rises",   64'(cs_rise[0] - c0), 64'd1);
    chk("b2b first_word", rx_prev[0], 64'hA5A5A5A5A5A5A5A5);
    chk("b2b second_word", rx_last[0], 64'h5A5A5A5A5A5A5A5A);
    chk("b2b target_word", tgt[0], 64'h5A5A5A5A5A5A5A5A);
    chk("b2b sck_period", 64'(per_err[0] - p0), 64'd0);

    // Abort after 10 SCK rises.
    saved = rxd_v[0];
    r0 = rises[0]; v0 = rxv_cnt[0]; g0 = gap[0];
    send(0, 64'h1122334455667788, 1'b1);
    wait_rises(0, r0 + 10);
    abt[0] = 1'b1;
    step();
    abt[0] = 1'b0;
    chk("abort cs",   64'(cs_v[0]),   64'd1);
    chk("abort sck",  64'(sck_v[0]),  64'd0);
    chk("abort copi", 64'(copi_v[0]), 64'd0);
    chk("abort busy", 64'(busy_v[0]), 64'd1);
    wait_idle(0);
    step();
    chk("abort rx_pulses", 64'(rxv_cnt[0] - v0), 64'd0);
    chk("abort rx_data",   rxd_v[0], saved);
    chk("abort sck_rises", 64'(rises[0] - r0), 64'd10);
    chk("abort cs_gap_ok", 64'((gap[0] - g0) >= CDA), 64'd1);
    frame("after_abort", 0, 64'h0F1E2D3C4B5A6978, 64'h0F1E2D3C4B5A6978);

    // Reset in the middle of a word.
    r0 = rises[0];
    send(0, 64'hFEEDFACE00C0FFEE, 1'b1);
    wait_rises(0, r0 + 20);
    resetn = 1'b0;
    #1;
    chk("midreset cs",       64'(cs_v[0]),  64'd1);
    chk("midreset sck",      64'(sck_v[0]), 64'd0);
    chk("midreset rx_valid", 64'(rxv_v[0]), 64'd0);
    chk("midreset tx_ready", 64'(rdy_v[0]), 64'd1);
    chk("midreset rx_data",  rxd_v[0],      64'd0);
    step();
    step();
    resetn = 1'b1;
    step();
    frame("after_reset", 0, 64'hCAFEF00D12345678, 64'hCAFEF00D12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
